pkt_reader: RTL and testbench

- Pop-side consumer for the FIFO valid/grant interface.
- Accepts words of DATA_WIDTH+1 bits. Bit DATA_WIDTH is the end-of-packet (last) flag; bits DATA_WIDTH-1:0 are payload.
- Assembles words into packets and computes per-packet length and a modular sum.
- Presents one descriptor per packet on a valid/grant output handshake and keeps a running packet count.

---
 rtl/pkt_reader_pkg.sv | 16 +
 rtl/pkt_reader.sv | 120 ++++++++++++
 tb/tb_pkt_reader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_reader_pkg.sv
// Shared types and helpers for the FIFO pop-side packet reader.
package pkt_reader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StDrain,
        StHold
    } state_e;

    // Position of the end-of-packet flag within a FIFO word.
    function automatic int unsigned last_bit(input int unsigned data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/pkt_reader.sv
// Pops words from a FIFO, assembles packets and emits one descriptor
// (length, modular sum, oversize error) per packet with a running count.
module pkt_reader
    import pkt_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MAX_PKT_LEN = 16,
    parameter int unsigned CNT_WIDTH   = 16,
    localparam int unsigned LenW       = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic [DATA_WIDTH:0]   pop_data_i,
    input  logic                  pop_valid_i,
    output logic                  pop_grant_o,
    output logic                  desc_valid_o,
    input  logic                  desc_grant_i,
    output logic [LenW-1:0]       desc_len_o,
    output logic [DATA_WIDTH-1:0] desc_sum_o,
    output logic                  desc_err_o,
    output logic [CNT_WIDTH-1:0]  pkt_cnt_o
);

    localparam int unsigned    LastBit = last_bit(DATA_WIDTH);
    localparam logic [LenW-1:0] MaxLen = LenW'(MAX_PKT_LEN);

    state_e                  state_q, state_d;
    logic [LenW-1:0]         len_q, len_d;
    logic [DATA_WIDTH-1:0]   sum_q, sum_d;
    logic                    err_q, err_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

    logic                    accept;
    logic                    last;
    logic [DATA_WIDTH-1:0]   payload;

    assign last    = pop_data_i[LastBit];
    assign payload = pop_data_i[DATA_WIDTH-1:0];

    always_comb begin
        pop_grant_o = 1'b0;
        unique case (state_q)
            StIdle:  pop_grant_o = enable_i;
            StRecv:  pop_grant_o = 1'b1;
            StDrain: pop_grant_o = 1'b1;
            StHold:  pop_grant_o = 1'b0;
            default: pop_grant_o = 1'b0;
        endcase
    end

    assign accept = pop_valid_i && pop_grant_o;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        sum_d        = sum_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        desc_valid_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    len_d   = LenW'(1);
                    sum_d   = payload;
                    err_d   = 1'b0;
                    state_d = last ? StHold : StRecv;
                end
            end
            StRecv: begin
                if (accept) begin
                    if (len_q < MaxLen) begin
                        len_d   = len_q + LenW'(1);
                        sum_d   = sum_q + payload;
                        state_d = last ? StHold : StRecv;
                    end else begin
                        // Overflow word is dropped; len/sum stay at the saturated values.
                        err_d   = 1'b1;
                        state_d = last ? StHold : StDrain;
                    end
                end
            end
            StDrain: begin
                if (accept && last) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                desc_valid_o = 1'b1;
                if (desc_grant_i) begin
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign desc_len_o = len_q;
    assign desc_sum_o = sum_q;
    assign desc_err_o = err_q;
    assign pkt_cnt_o  = cnt_q;

endmodule

// File: tb/tb_pkt_reader.sv
// Scoreboard bench for pkt_reader with MAX_PKT_LEN=4: stimulus queues expected
// descriptors, a monitor pops and compares them at each descriptor handoff.
module tb_pkt_reader;

    localparam int unsigned DW   = 32;
    localparam int unsigned MaxL = 4;
    localparam int unsigned CW   = 16;
    localparam int unsigned LW   = $clog2(MaxL + 1);

    typedef struct packed {
        logic [LW-1:0] len;
        logic [DW-1:0] sum;
        logic          err;
    } desc_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable_i;
    logic [DW:0]   pop_data_i;
    logic          pop_valid_i;
    logic          pop_grant_o;
    logic          desc_valid_o;
    logic          desc_grant_i;
    logic [LW-1:0] desc_len_o;
    logic [DW-1:0] desc_sum_o;
    logic          desc_err_o;
    logic [CW-1:0] pkt_cnt_o;

    int compared   = 0;
    int mismatched = 0;
    int accepted   = 0;
    desc_t exp_q[$];

    always #5 clk = ~clk;

    pkt_reader #(
        .DATA_WIDTH (DW),
        .MAX_PKT_LEN(MaxL),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (enable_i),
        .pop_data_i  (pop_data_i),
        .pop_valid_i (pop_valid_i),
        .pop_grant_o (pop_grant_o),
        .desc_valid_o(desc_valid_o),
        .desc_grant_i(desc_grant_i),
        .desc_len_o  (desc_len_o),
        .desc_sum_o  (desc_sum_o),
        .desc_err_o  (desc_err_o),
        .pkt_cnt_o   (pkt_cnt_o)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Word accounting and the no-grant-while-holding rule, sampled mid-cycle.
    always @(negedge clk) begin
        if (pop_valid_i && pop_grant_o) accepted++;
        if (desc_valid_o) chk("grant_while_hold", 64'(pop_grant_o), 64'd0);
    end

    // Descriptor monitor: compares at each handoff cycle.
    initial begin
        desc_t e;
        forever begin
            @(negedge clk);
            if (!rst && desc_valid_o && desc_grant_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_desc", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("desc_len", 64'(desc_len_o), 64'(e.len));
                    chk("desc_sum", 64'(desc_sum_o), 64'(e.sum));
                    chk("desc_err", 64'(desc_err_o), 64'(e.err));
                end
            end
        end
    end

    task automatic send(input logic lst, input logic [DW-1:0] d);
        bit granted = 1'b0;
        pop_valid_i = 1'b1;
        pop_data_i  = {lst, d};
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (pop_grant_o) begin
                granted = 1'b1;
                break;
            end
        end
        if (!granted) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        pop_valid_i = 1'b0;
    endtask

    task automatic push(input int unsigned len, input logic [DW-1:0] sum, input logic err);
        desc_t e;
        e.len = LW'(len);
        e.sum = sum;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int acc0;
        rst          = 1'b1;
        enable_i     = 1'b0;
        pop_valid_i  = 1'b0;
        pop_data_i   = '0;
        desc_grant_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 64'(pop_grant_o), 64'd0);
        chk("rst_valid", 64'(desc_valid_o), 64'd0);
        chk("rst_len", 64'(desc_len_o), 64'd0);
        chk("rst_sum", 64'(desc_sum_o), 64'd0);
        chk("rst_err", 64'(desc_err_o), 64'd0);
        chk("rst_cnt", 64'(pkt_cnt_o), 64'd0);
        rst          = 1'b0;
        enable_i     = 1'b1;
        desc_grant_i = 1'b1;

        // Single-word packet; descriptor appears the cycle after accept.
        push(1, 32'h5, 1'b0);
        send(1'b1, 32'h5);
        chk("single_valid_latency", 64'(desc_valid_o), 64'd1);
        settle();
        chk("cnt_after_single", 64'(pkt_cnt_o), 64'd1);

        // Three back-to-back words.
        push(3, 32'd6, 1'b0);
        send(1'b0, 32'd1);
        send(1'b0, 32'd2);
        send(1'b1, 32'd3);
        settle();
        chk("cnt_after_three", 64'(pkt_cnt_o), 64'd2);

        // Descriptor backpressure with a word waiting in the FIFO.
        desc_grant_i = 1'b0;
        push(2, 32'd9, 1'b0);
        send(1'b0, 32'd4);
        send(1'b1, 32'd5);
        pop_valid_i = 1'b1;
        pop_data_i  = {1'b1, 32'd99};
        acc0 = accepted;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(desc_valid_o), 64'd1);
            chk("bp_len", 64'(desc_len_o), 64'd2);
            chk("bp_sum", 64'(desc_sum_o), 64'd9);
        end
        chk("bp_no_pop", 64'(accepted - acc0), 64'd0);
        @(posedge clk);
        #1;
        pop_valid_i  = 1'b0;
        desc_grant_i = 1'b1;
        settle();
        chk("cnt_after_bp", 64'(pkt_cnt_o), 64'd3);

        // Oversize: six words against a limit of four.
        push(4, 32'd10, 1'b1);
        acc0 = accepted;
        for (int i = 1; i <= 6; i++) send(i == 6, DW'(i));
        settle();
        chk("oversize_popped", 64'(accepted - acc0), 64'd6);

        // Sum wraps modulo 2^32.
        push(2, 32'd1, 1'b0);
        send(1'b0, 32'hFFFF_FFFF);
        send(1'b1, 32'h2);
        settle();

        // Exactly MAX_PKT_LEN words is legal.
        push(4, 32'd100, 1'b0);
        send(1'b0, 32'd10);
        send(1'b0, 32'd20);
        send(1'b0, 32'd30);
        send(1'b1, 32'd40);
        settle();
        chk("cnt_after_max", 64'(pkt_cnt_o), 64'd6);

        // Reset mid-packet discards the partial packet and the count.
        send(1'b0, 32'd8);
        send(1'b0, 32'd9);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("cnt_after_rst", 64'(pkt_cnt_o), 64'd0);
        push(1, 32'd7, 1'b0);
        send(1'b1, 32'd7);
        settle();
        chk("cnt_post_rst_pkt", 64'(pkt_cnt_o), 64'd1);

        // Disabled in IDLE: nothing is taken.
        enable_i    = 1'b0;
        pop_valid_i = 1'b1;
        pop_data_i  = {1'b1, 32'd3};
        acc0 = accepted;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("disabled_grant", 64'(pop_grant_o), 64'd0);
        end
        chk("disabled_no_pop", 64'(accepted - acc0), 64'd0);
        @(posedge clk);
        #1;
        pop_valid_i = 1'b0;

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
